// File: rtl/div_unit_param_if.sv
// rtl/div_unit_param_if.sv - request/result handshake bundle for div_unit_param
interface div_unit_param_if #(
    parameter int XLEN = 64
);
    logic            div_req_i;
    logic            div_ready_o;
    logic [3:0]      div_op_i;
    logic            word_op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            flush_i;
    logic            div_valid_o;
    logic            result_ready_i;
    logic [XLEN-1:0] result_o;
    logic [2:0]      div_status_o;

    modport master (
        output div_req_i, div_op_i, word_op_i, dividend_i, divisor_i, flush_i, result_ready_i,
        input  div_ready_o, div_valid_o, result_o, div_status_o
    );

    modport slave (
        input  div_req_i, div_op_i, word_op_i, dividend_i, divisor_i, flush_i, result_ready_i,
        output div_ready_o, div_valid_o, result_o, div_status_o
    );
endinterface

// File: rtl/div_unit_param.sv
// rtl/div_unit_param.sv - iterative restoring divider, STEPS_PER_CYCLE bits/cycle; DIV_EARLY_OUT_EN skips leading dividend zeros
module div_unit_param #(
    parameter int XLEN            = 64,
    parameter int STEPS_PER_CYCLE = 1
) (
    input logic             clk,
    input logic             rst,
    div_unit_param_if.slave bus
);
    localparam int S   = STEPS_PER_CYCLE;
    localparam int WSH = XLEN - 32;
    localparam int CW  = $clog2(XLEN) + 2;

    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_DIVU = 4'd5;
    localparam logic [3:0] OP_REM  = 4'd6;
    localparam logic [3:0] OP_REMU = 4'd7;

    localparam logic [2:0] ST_NONE          = 3'd0;
    localparam logic [2:0] ST_ZERO_DIVISOR  = 3'd1;
    localparam logic [2:0] ST_OVERFLOW      = 3'd2;
    localparam logic [2:0] ST_ZERO_DIVIDEND = 3'd3;
    localparam logic [2:0] ST_SHORT_DIV     = 3'd4;

    typedef enum logic [1:0] {
        S_DIV_IDLE,
        S_DIV_RUN,
        S_DIV_OUT_SC,
        S_DIV_OUT_CC
    } div_state_t;

    // Low 32 bits sign-extended to XLEN (identity width when XLEN is 32).
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] t;
        t = v << WSH;
        return $signed(t) >>> WSH;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] t;
        t = v << WSH;
        return t >> WSH;
    endfunction

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            is_rem_q;
    logic            w32_q;
    logic            short_q;
    logic [XLEN-1:0] result_q;
    logic [2:0]      status_q;

    logic            in_signed, in_rem, in_w32;
    logic            a_neg, b_neg, zero_dvs, ovf, zero_dvd, special;
    logic [XLEN-1:0] a_ext, b_ext, min_w, abs_a, abs_b, aligned, pre_quo;
    logic [XLEN-1:0] sc_quo, sc_rem, sc_res, sc_fin;
    logic [2:0]      sc_status;
    logic [CW-1:0]   cnt_full, cnt_ld;
    int              wsh_amt;
`ifdef DIV_EARLY_OUT_EN
    int              lz, lz_s;
`endif

    // Accept-cycle operand conditioning, special-case classification and counter preload.
    always_comb begin
        in_signed = (bus.div_op_i == OP_DIV) || (bus.div_op_i == OP_REM);
        in_rem    = (bus.div_op_i == OP_REM) || (bus.div_op_i == OP_REMU);
        in_w32    = (XLEN == 64) && bus.word_op_i;
        if (in_w32) begin
            a_ext    = in_signed ? sext32(bus.dividend_i) : zext32(bus.dividend_i);
            b_ext    = in_signed ? sext32(bus.divisor_i)  : zext32(bus.divisor_i);
            min_w    = {XLEN{1'b1}} << 31;
            cnt_full = CW'(32 / S);
            wsh_amt  = WSH;
        end else begin
            a_ext    = bus.dividend_i;
            b_ext    = bus.divisor_i;
            min_w    = {XLEN{1'b1}} << (XLEN - 1);
            cnt_full = CW'(XLEN / S);
            wsh_amt  = 0;
        end
        a_neg    = in_signed && a_ext[XLEN-1];
        b_neg    = in_signed && b_ext[XLEN-1];
        abs_a    = a_neg ? -a_ext : a_ext;
        abs_b    = b_neg ? -b_ext : b_ext;
        zero_dvs = (b_ext == '0);
        ovf      = in_signed && (a_ext == min_w) && (b_ext == '1);
        zero_dvd = (a_ext == '0);
        special  = zero_dvs || ovf || zero_dvd;

        sc_quo    = '0;
        sc_rem    = '0;
        sc_status = ST_ZERO_DIVIDEND;
        if (zero_dvs) begin
            sc_quo    = '1;
            sc_rem    = a_ext;
            sc_status = ST_ZERO_DIVISOR;
        end else if (ovf) begin
            sc_quo    = a_ext;
            sc_status = ST_OVERFLOW;
        end
        sc_res = in_rem ? sc_rem : sc_quo;
        sc_fin = in_w32 ? sext32(sc_res) : sc_res;

        // Dividend is left-aligned to the top of the register so W=32 runs exactly 32 steps.
        aligned = abs_a << wsh_amt;
`ifdef DIV_EARLY_OUT_EN
        lz = XLEN;
        for (int i = 0; i < XLEN; i++) begin
            if (aligned[i]) lz = XLEN - 1 - i;
        end
        lz_s    = lz - (lz % S);
        pre_quo = aligned << lz_s;
        cnt_ld  = cnt_full - CW'(lz_s / S);
`else
        pre_quo = aligned;
        cnt_ld  = cnt_full;
`endif
    end

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo, fin_quo, fin_rem, fin_res, cc_fin;

    // S chained restoring steps per cycle, plus sign fix-up and result select for the last one.
    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        for (int s = 0; s < S; s++) begin
            step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (step_rem >= {1'b0, dvs_q}) begin
                step_rem    = step_rem - {1'b0, dvs_q};
                step_quo[0] = 1'b1;
            end
        end
        fin_quo = q_neg_q ? -step_quo : step_quo;
        fin_rem = r_neg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
        fin_res = is_rem_q ? fin_rem : fin_quo;
        cc_fin  = w32_q ? sext32(fin_res) : fin_res;
    end

    // Control FSM and datapath registers; flush wins over accept and over the result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_DIV_IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            w32_q    <= 1'b0;
            short_q  <= 1'b0;
            result_q <= '0;
            status_q <= ST_NONE;
        end else if (bus.flush_i) begin
            state <= S_DIV_IDLE;
        end else begin
            case (state)
                S_DIV_IDLE: begin
                    if (bus.div_req_i) begin
                        is_rem_q <= in_rem;
                        w32_q    <= in_w32;
                        if (special) begin
                            result_q <= sc_fin;
                            status_q <= sc_status;
                            state    <= S_DIV_OUT_SC;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= pre_quo;
                            dvs_q   <= abs_b;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            cnt     <= cnt_ld;
                            short_q <= (cnt_ld < cnt_full);
                            state   <= S_DIV_RUN;
                        end
                    end
                end
                S_DIV_RUN: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result_q <= cc_fin;
                        status_q <= short_q ? ST_SHORT_DIV : ST_NONE;
                        state    <= S_DIV_OUT_CC;
                    end
                end
                default: begin
                    if (bus.result_ready_i) state <= S_DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.div_ready_o  = (state == S_DIV_IDLE);
    assign bus.div_valid_o  = (state == S_DIV_OUT_SC) || (state == S_DIV_OUT_CC);
    assign bus.result_o     = result_q;
    assign bus.div_status_o = status_q;
endmodule

// File: tb/tb_div_unit_param.sv
// tb/tb_div_unit_param.sv - table-driven scoreboard bench for div_unit_param
module tb_div_unit_param;
    localparam int XLEN = 64;
`ifdef DIV_EARLY_OUT_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif

    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_DIVU = 4'd5;
    localparam logic [3:0] OP_REM  = 4'd6;
    localparam logic [3:0] OP_REMU = 4'd7;

    localparam logic [2:0] ST_NONE   = 3'd0;
    localparam logic [2:0] ST_ZDVS   = 3'd1;
    localparam logic [2:0] ST_OVF    = 3'd2;
    localparam logic [2:0] ST_ZDVD   = 3'd3;
    localparam logic [2:0] ST_SHORT  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_param_if #(.XLEN(XLEN)) bus ();
    div_unit_param #(.XLEN(XLEN), .STEPS_PER_CYCLE(STEPS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [2:0]  st;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  st;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_applied = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V M semantics, special-case status and expected latency.
    function automatic void model(input logic [3:0] op, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res,
                                  output logic [2:0] st, output int lat);
        logic        sgn, isrem;
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q64, r64;
        int          wd, n;
`ifdef DIV_EARLY_OUT_EN
        logic [63:0] mag;
        int          lz;
`endif
        sgn   = (op == OP_DIV) || (op == OP_REM);
        isrem = (op == OP_REM) || (op == OP_REMU);
        wd    = w ? 32 : 64;
        a32   = a[31:0];
        b32   = b[31:0];
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; st = ST_ZDVS; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; st = ST_OVF; end
            else if (a32 == 0) begin q32 = 0; r32 = 0; st = ST_ZDVD; end
            else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); st = ST_NONE; end
            else begin q32 = a32 / b32; r32 = a32 % b32; st = ST_NONE; end
            res32 = isrem ? r32 : q32;
            res   = {{32{res32[31]}}, res32};
        end else begin
            if (b == 0) begin q64 = '1; r64 = a; st = ST_ZDVS; end
            else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 0; st = ST_OVF; end
            else if (a == 0) begin q64 = 0; r64 = 0; st = ST_ZDVD; end
            else if (sgn) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); st = ST_NONE; end
            else begin q64 = a / b; r64 = a % b; st = ST_NONE; end
            res = isrem ? r64 : q64;
        end
        if (st != ST_NONE) begin
            lat = 1;
        end else begin
            n = wd / STEPS;
`ifdef DIV_EARLY_OUT_EN
            if (w) mag = (sgn && a32[31]) ? {32'h0, -a32} : {32'h0, a32};
            else   mag = (sgn && a[63]) ? -a : a;
            lz = wd;
            for (int i = 0; i < wd; i++) if (mag[i]) lz = wd - 1 - i;
            n = (wd - lz + STEPS - 1) / STEPS;
            if (n < 1) n = 1;
            if (n < wd / STEPS) st = ST_SHORT;
`endif
            lat = n + 1;
        end
    endfunction

    // Drive one request at a negedge and push its expectation on the accept edge.
    task automatic issue(input string name, input logic [3:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input logic [2:0] exp_st,
                         output int mlat);
        exp_t        e;
        logic [63:0] mres;
        logic [2:0]  mst;
        int          guard;
        model(op, w, a, b, mres, mst, mlat);
        e.res = exp_res;
        e.st  = (exp_st == ST_NONE) ? mst : exp_st;
        guard = 0;
        while (!bus.div_ready_o && guard < 200) begin @(negedge clk); guard++; end
        check({name, " ready"}, 64'(bus.div_ready_o), 64'd1);
        bus.div_req_i  = 1'b1;
        bus.div_op_i   = op;
        bus.word_op_i  = w;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.div_req_i  = 1'b0;
        bus.div_op_i   = 4'(4 + $urandom_range(0, 3));
        bus.word_op_i  = 1'($urandom_range(0, 1));
        bus.dividend_i = {$urandom, $urandom};
        bus.divisor_i  = {$urandom, $urandom};
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res, input logic [2:0] exp_st,
                          input int hold);
        exp_t e;
        int   mlat, lat;
        issue(name, op, w, a, b, exp_res, exp_st, mlat);
        lat = 1;
        @(negedge clk);
        while (!bus.div_valid_o && lat < 200) begin
            bus.div_req_i = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus.div_req_i = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(mlat));
        for (int k = 0; k < hold; k++) begin
            check({name, " held result"}, bus.result_o, sb[0].res);
            check({name, " held ready"}, 64'(bus.div_ready_o), 64'd0);
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({name, " result"}, bus.result_o, e.res);
            check({name, " status"}, 64'(bus.div_status_o), 64'(e.st));
        end
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        bus.result_ready_i = 1'b0;
        check({name, " valid after handshake"}, 64'(bus.div_valid_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          mlat;
        logic [63:0] ra, rb, mres;
        logic [2:0]  mst;
        logic [3:0]  rop;
        logic        rw;

        vecs[0]  = '{"divu100_7",   OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, ST_NONE};
        vecs[1]  = '{"remu100_7",   OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, ST_NONE};
        vecs[2]  = '{"div_m7_2",    OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ST_NONE};
        vecs[3]  = '{"rem_m7_2",    OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ST_NONE};
        vecs[4]  = '{"rem_7_m2",    OP_REM,  1'b0, 64'd7, -64'sd2, 64'd1, ST_NONE};
        vecs[5]  = '{"divu_by0",    OP_DIVU, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, ST_ZDVS};
        vecs[6]  = '{"div_ovf",     OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, ST_OVF};
        vecs[7]  = '{"rem_ovf",     OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, ST_OVF};
        vecs[8]  = '{"divuw_sext",  OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, ST_NONE};
        vecs[9]  = '{"divw_hi",     OP_DIV,  1'b1, 64'h1_0000_0005, 64'd5, 64'd1, ST_NONE};
        vecs[10] = '{"divu9_3",     OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, ST_NONE};
        vecs[11] = '{"rem_zdvd",    OP_REM,  1'b0, 64'd0, 64'd5, 64'd0, ST_ZDVD};
        vecs[12] = '{"remu_by0",    OP_REMU, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'hDEAD_BEEF_0123_4567, ST_ZDVS};
        vecs[13] = '{"divw_ovf",    OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, ST_OVF};
        vecs[14] = '{"divu_max",    OP_DIVU, 1'b0, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, ST_NONE};
        vecs[15] = '{"remuw_f",     OP_REMU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'hF, ST_NONE};

        bus.div_req_i      = 1'b0;
        bus.div_op_i       = OP_DIVU;
        bus.word_op_i      = 1'b0;
        bus.dividend_i     = '0;
        bus.divisor_i      = '0;
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;

        repeat (2) @(negedge clk);
        check("reset ready",  64'(bus.div_ready_o),  64'd1);
        check("reset valid",  64'(bus.div_valid_o),  64'd0);
        check("reset result", bus.result_o,          64'd0);
        check("reset status", 64'(bus.div_status_o), 64'(ST_NONE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st, 0);

        // Backpressure: result held for 10 cycles with ready low.
        run_op("backpressure", OP_DIVU, 1'b0, 64'd1000, 64'd33, 64'd30, ST_NONE, 10);

        // Flush in RUN with result_ready high; then a fresh request must be correct.
        issue("flush_run", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, ST_NONE, mlat);
        repeat (20) @(negedge clk);
        bus.flush_i        = 1'b1;
        bus.result_ready_i = 1'b1;
        bus.div_req_i      = 1'b1;
        @(negedge clk);
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        bus.div_req_i      = 1'b0;
        void'(sb.pop_front());
        check("flush_run valid", 64'(bus.div_valid_o), 64'd0);
        check("flush_run ready", 64'(bus.div_ready_o), 64'd1);
        run_op("after_flush_run", OP_REM, 1'b0, -64'sd100, 64'd7, -64'sd2, ST_NONE, 0);

        // Flush in an OUT state drops the result even with result_ready high.
        issue("flush_out", OP_DIVU, 1'b0, 64'd5, 64'd0, '1, ST_ZDVS, mlat);
        @(negedge clk);
        check("flush_out valid before", 64'(bus.div_valid_o), 64'd1);
        bus.flush_i        = 1'b1;
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        void'(sb.pop_front());
        check("flush_out valid", 64'(bus.div_valid_o), 64'd0);
        check("flush_out ready", 64'(bus.div_ready_o), 64'd1);

        // Asynchronous reset in the middle of RUN.
        issue("rst_run", OP_DIVU, 1'b0, 64'hFFFF_0000_0000_0000, 64'd3, 64'h5555_0000_0000_0000, ST_NONE, mlat);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_run ready",  64'(bus.div_ready_o),  64'd1);
        check("rst_run valid",  64'(bus.div_valid_o),  64'd0);
        check("rst_run result", bus.result_o,          64'd0);
        check("rst_run status", 64'(bus.div_status_o), 64'(ST_NONE));
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random operands against the model.
        for (int i = 0; i < 8; i++) begin
            rop = 4'(4 + $urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom} >> $urandom_range(0, 63);
            rb  = {$urandom, $urandom} >> $urandom_range(20, 63);
            model(rop, rw, ra, rb, mres, mst, mlat);
            run_op("random", rop, rw, ra, rb, mres, mst, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end
endmodule
